// File: rtl/pc_return_stack.sv
// Return-address stack for the PIC16C57 program counter: a shift register of DEPTH entries.
// Overflow and underflow wrap silently like silicon; the sticky ovf/unf flags are debug aids.
module pc_return_stack #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2,
  parameter int CNTW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] tos,
  output logic [CNTW-1:0]  level,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] entry [DEPTH];

  assign tos   = entry[0];
  assign full  = (level == CNTW'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          for (int i = 1; i < DEPTH; i++) entry[i] <= entry[i-1];
          entry[0] <= push_data;
          if (!full) level <= level + CNTW'(1);
        end
        2'b01: begin
          // The bottom entry keeps its value, so repeated pops return a duplicate.
          for (int i = 0; i < DEPTH-1; i++) entry[i] <= entry[i+1];
          if (!empty) level <= level - CNTW'(1);
        end
        2'b11: entry[0] <= push_data;
        default: ;
      endcase

      // Clearing wins over setting in the same cycle.
      if (clr_flags) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        if (push && !pop && full)  ovf <= 1'b1;
        if (pop  && !push && empty) unf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// Bench for pc_return_stack: async reset checks, a directed vector table, then random
// traffic compared against a queue-based model of the stack.
module tb_pc_return_stack;

  localparam int WIDTH = 11;
  localparam int DEPTH = 2;
  localparam int CNTW  = 2;

  logic             clk;
  logic             rst;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic             clr_flags;
  logic [WIDTH-1:0] tos;
  logic [CNTW-1:0]  level;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  int vectors;
  int miscompares;

  pc_return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clr_flags(clr_flags), .tos(tos), .level(level), .full(full),
    .empty(empty), .ovf(ovf), .unf(unf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic             p;
    logic             q;
    logic             c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e_tos;
    logic [CNTW-1:0]  e_level;
    logic             e_full;
    logic             e_empty;
    logic             e_ovf;
    logic             e_unf;
  } vec_t;

  vec_t tbl [$];

  // behavioural model: all DEPTH entries as a queue, index 0 = top
  logic [WIDTH-1:0] m_stk [$];
  int               m_level;
  logic             m_ovf;
  logic             m_unf;

  // scoreboard
  logic [WIDTH+CNTW+3:0] exp_q [$];

  function automatic logic [WIDTH+CNTW+3:0] pack(logic [WIDTH-1:0] t, logic [CNTW-1:0] l,
                                                 logic f, logic e, logic o, logic u);
    return {t, l, f, e, o, u};
  endfunction

  task automatic check(input string name);
    logic [WIDTH+CNTW+3:0] exp_v;
    logic [WIDTH+CNTW+3:0] got;
    exp_v = exp_q.pop_front();
    got   = pack(tos, level, full, empty, ovf, unf);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got tos=%h level=%0d full=%b empty=%b ovf=%b unf=%b, need tos=%h level=%0d full=%b empty=%b ovf=%b unf=%b",
               name, got[WIDTH+CNTW+3:CNTW+4], got[CNTW+3:4], got[3], got[2], got[1], got[0],
               exp_v[WIDTH+CNTW+3:CNTW+4], exp_v[CNTW+3:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  // driver tasks
  task automatic drive(input logic p, input logic q, input logic c, input logic [WIDTH-1:0] d);
    @(negedge clk);
    push = p; pop = q; clr_flags = c; push_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_flags = 1'b0; push_data = '0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic void model_reset();
    m_stk.delete();
    for (int i = 0; i < DEPTH; i++) m_stk.push_back('0);
    m_level = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endfunction

  function automatic void model_step(logic p, logic q, logic c, logic [WIDTH-1:0] d);
    logic set_o, set_u;
    set_o = p && !q && (m_level == DEPTH);
    set_u = q && !p && (m_level == 0);
    if (p && !q) begin
      m_stk.push_front(d);
      void'(m_stk.pop_back());
      m_level = (m_level + 1 > DEPTH) ? DEPTH : m_level + 1;
    end else if (q && !p) begin
      m_stk.push_back(m_stk[DEPTH-1]);
      void'(m_stk.pop_front());
      m_level = (m_level - 1 < 0) ? 0 : m_level - 1;
    end else if (p && q) begin
      m_stk[0] = d;
    end
    if (c) begin
      m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_ovf = m_ovf | set_o;
      m_unf = m_unf | set_u;
    end
  endfunction

  function automatic void add(logic p, logic q, logic c, logic [WIDTH-1:0] d, logic [WIDTH-1:0] t,
                              logic [CNTW-1:0] l, logic f, logic e, logic o, logic u);
    vec_t v;
    v.p = p; v.q = q; v.c = c; v.d = d;
    v.e_tos = t; v.e_level = l; v.e_full = f; v.e_empty = e; v.e_ovf = o; v.e_unf = u;
    tbl.push_back(v);
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_flags = 1'b0; push_data = '0;

    // power-on reset
    #1 rst = 1'b0;
    #1;
    exp_q.push_back(pack('0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
    check("por");
    @(negedge clk);
    rst = 1'b1;

    // async reset mid-stream with push held high
    drive(1'b1, 1'b0, 1'b0, 11'h5A5);
    drive(1'b1, 1'b0, 1'b0, 11'h3C3);
    drive(1'b1, 1'b0, 1'b0, 11'h111);
    exp_q.push_back(pack(11'h111, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0));
    check("pre_reset");
    #1 rst = 1'b0;
    #1;
    exp_q.push_back(pack('0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
    check("async_reset");
    @(posedge clk);
    #1;
    exp_q.push_back(pack('0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
    check("reset_hold_push");
    @(negedge clk);
    push_data = 11'h123;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(pack(11'h123, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    check("first_push");

    // directed table
    //   p  q  c  data     tos      lvl f  e  o  u
    add(1, 0, 0, 11'h0A0, 11'h0A0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 11'h7FF, 11'h7FF, 2, 1, 0, 0, 0);
    add(0, 1, 0, 11'h000, 11'h0A0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 11'h000, 11'h0A0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 11'h001, 11'h001, 1, 0, 0, 0, 0);
    add(1, 0, 0, 11'h002, 11'h002, 2, 1, 0, 0, 0);
    add(1, 0, 0, 11'h003, 11'h003, 2, 1, 0, 1, 0);
    add(0, 1, 0, 11'h000, 11'h002, 1, 0, 0, 1, 0);
    add(0, 1, 0, 11'h000, 11'h002, 0, 0, 1, 1, 0);
    add(0, 1, 0, 11'h000, 11'h002, 0, 0, 1, 1, 1);
    add(0, 0, 1, 11'h000, 11'h002, 0, 0, 1, 0, 0);
    add(1, 0, 0, 11'h055, 11'h055, 1, 0, 0, 0, 0);
    add(1, 1, 0, 11'h2AA, 11'h2AA, 1, 0, 0, 0, 0);
    add(0, 1, 0, 11'h000, 11'h002, 0, 0, 1, 0, 0);
    add(1, 1, 0, 11'h111, 11'h111, 0, 0, 1, 0, 0);
    add(0, 1, 1, 11'h000, 11'h002, 0, 0, 1, 0, 0);
    add(0, 1, 0, 11'h000, 11'h002, 0, 0, 1, 0, 1);
    add(1, 0, 1, 11'h3FF, 11'h3FF, 1, 0, 0, 0, 0);
    add(1, 0, 0, 11'h100, 11'h100, 2, 1, 0, 0, 0);
    add(1, 1, 0, 11'h200, 11'h200, 2, 1, 0, 0, 0);
    add(0, 1, 0, 11'h000, 11'h3FF, 1, 0, 0, 0, 0);
    add(0, 0, 0, 11'h7AB, 11'h3FF, 1, 0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].p, tbl[i].q, tbl[i].c, tbl[i].d);
      exp_q.push_back(pack(tbl[i].e_tos, tbl[i].e_level, tbl[i].e_full, tbl[i].e_empty,
                           tbl[i].e_ovf, tbl[i].e_unf));
      check($sformatf("tbl%0d", i));
    end

    // random traffic against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic p, q, c;
      logic [WIDTH-1:0] d;
      p = ($urandom_range(0, 99) < 45);
      q = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 8);
      d = WIDTH'($urandom);
      drive(p, q, c, d);
      model_step(p, q, c, d);
      exp_q.push_back(pack(m_stk[0], CNTW'(m_level), m_level == DEPTH, m_level == 0, m_ovf, m_unf));
      check($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
